// File: rtl/debounce_multi.sv
// debounce_multi: N-channel switch/button debouncer.
// Each channel has a SYNC_STAGES-deep synchroniser, a stability counter
// and a two-state FSM (the state is the debounced level). A level change
// is accepted only after TIME consecutive synchronised cycles that
// disagree with the current level. Rise and fall strobes are registered
// and coincide with the o_out change.
// Optional long-press detection is compiled in with `define DEBOUNCE_HOLD_EN;
// without it o_hold is tied low and no hold counters exist.
module debounce_multi #(
    parameter int                  CHANNELS    = 4,
    parameter int                  TIME        = 500000,
    parameter int                  SYNC_STAGES = 2,
    parameter logic [CHANNELS-1:0] RESET_LEVEL = {CHANNELS{1'b0}},
    parameter int                  HOLD_TIME   = 125000000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CHANNELS-1:0] i_in,
    output logic [CHANNELS-1:0] o_out,
    output logic [CHANNELS-1:0] o_rise,
    output logic [CHANNELS-1:0] o_fall,
    output logic [CHANNELS-1:0] o_busy,
    output logic [CHANNELS-1:0] o_hold
);

    localparam int               CNT_W    = $clog2(TIME);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIME - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic {
        STABLE_LO = 1'b0,
        STABLE_HI = 1'b1
    } state_t;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        logic [SYNC_STAGES-1:0] sync_r;
        logic                   sample_s;
        state_t                 state_r;
        state_t                 state_nxt_s;
        logic [CNT_W-1:0]       cnt_r;
        logic [CNT_W-1:0]       cnt_nxt_s;
        logic                   rise_r;
        logic                   fall_r;
        logic                   rise_nxt_s;
        logic                   fall_nxt_s;
        logic                   out_s;
        logic                   busy_s;

        // Synchroniser chain: the raw input enters at bit 0, the FSM only sees the last stage.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                sync_r <= {SYNC_STAGES{RESET_LEVEL[g]}};
            end else begin
                sync_r <= {sync_r[SYNC_STAGES-2:0], i_in[g]};
            end
        end

        assign sample_s = sync_r[SYNC_STAGES-1];

        // State register: debounced level, stability counter and registered strobes.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                state_r <= state_t'(RESET_LEVEL[g]);
                cnt_r   <= CNT_ZERO;
                rise_r  <= 1'b0;
                fall_r  <= 1'b0;
            end else begin
                state_r <= state_nxt_s;
                cnt_r   <= cnt_nxt_s;
                rise_r  <= rise_nxt_s;
                fall_r  <= fall_nxt_s;
            end
        end

        // Next-state logic: any sample that agrees with the current level restarts qualification.
        always_comb begin
            state_nxt_s = state_r;
            cnt_nxt_s   = CNT_ZERO;
            rise_nxt_s  = 1'b0;
            fall_nxt_s  = 1'b0;
            case (state_r)
                STABLE_LO: begin
                    if (sample_s) begin
                        if (cnt_r == CNT_MAX) begin
                            state_nxt_s = STABLE_HI;
                            cnt_nxt_s   = CNT_ZERO;
                            rise_nxt_s  = 1'b1;
                        end else begin
                            cnt_nxt_s = cnt_r + CNT_ONE;
                        end
                    end else begin
                        cnt_nxt_s = CNT_ZERO;
                    end
                end
                STABLE_HI: begin
                    if (!sample_s) begin
                        if (cnt_r == CNT_MAX) begin
                            state_nxt_s = STABLE_LO;
                            cnt_nxt_s   = CNT_ZERO;
                            fall_nxt_s  = 1'b1;
                        end else begin
                            cnt_nxt_s = cnt_r + CNT_ONE;
                        end
                    end else begin
                        cnt_nxt_s = CNT_ZERO;
                    end
                end
                default: begin
                    state_nxt_s = STABLE_LO;
                    cnt_nxt_s   = CNT_ZERO;
                end
            endcase
        end

        // Output decode: level follows the state, busy flags an in-progress qualification.
        always_comb begin
            out_s  = (state_r == STABLE_HI);
            busy_s = (cnt_r != CNT_ZERO);
        end

        assign o_out[g]  = out_s;
        assign o_busy[g] = busy_s;
        assign o_rise[g] = rise_r;
        assign o_fall[g] = fall_r;

`ifdef DEBOUNCE_HOLD_EN
        localparam int               HOLD_W   = $clog2(HOLD_TIME);
        localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_TIME - 1);
        localparam logic [HOLD_W-1:0] HOLD_ONE = HOLD_W'(1);

        logic [HOLD_W-1:0] hold_cnt_r;
        logic              hold_done_r;
        logic              hold_r;

        // Long-press timer: runs while the debounced level is high; the rise edge
        // itself sees the low state and clears it, so the strobe lands HOLD_TIME after o_rise.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                hold_cnt_r  <= {HOLD_W{1'b0}};
                hold_done_r <= 1'b0;
                hold_r      <= 1'b0;
            end else if (state_r == STABLE_LO) begin
                hold_cnt_r  <= {HOLD_W{1'b0}};
                hold_done_r <= 1'b0;
                hold_r      <= 1'b0;
            end else if (hold_cnt_r == HOLD_MAX) begin
                hold_r      <= !hold_done_r;
                hold_done_r <= 1'b1;
            end else begin
                hold_cnt_r  <= hold_cnt_r + HOLD_ONE;
                hold_r      <= 1'b0;
            end
        end

        assign o_hold[g] = hold_r;
`else
        assign o_hold[g] = 1'b0;
`endif
    end

endmodule

// File: tb/tb_debounce_multi.sv
// Directed bench for debounce_multi (CHANNELS=4, TIME=8, SYNC_STAGES=2,
// RESET_LEVEL=4'b0100, HOLD_TIME=32). Inputs are driven and outputs
// sampled on the falling clock edge.
module tb_debounce_multi;

    logic       clk;
    logic       rst;
    logic [3:0] i_in;
    logic [3:0] o_out;
    logic [3:0] o_rise;
    logic [3:0] o_fall;
    logic [3:0] o_busy;
    logic [3:0] o_hold;

`ifdef DEBOUNCE_HOLD_EN
    localparam bit HOLD_EN = 1'b1;
`else
    localparam bit HOLD_EN = 1'b0;
`endif

    debounce_multi #(
        .CHANNELS   (4),
        .TIME       (8),
        .SYNC_STAGES(2),
        .RESET_LEVEL(4'b0100),
        .HOLD_TIME  (32)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .i_in  (i_in),
        .o_out (o_out),
        .o_rise(o_rise),
        .o_fall(o_fall),
        .o_busy(o_busy),
        .o_hold(o_hold)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] in;
        logic [3:0] out;
        logic [3:0] rise;
        logic [3:0] fall;
        logic [3:0] busy;
    } vec_t;

    vec_t tbl [48];
    int   n_total = 0;
    int   n_pass  = 0;

    task automatic chk(input string name, input int idx, input logic [3:0] act, input logic [3:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s @%0d: got %b expected %b", name, idx, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        logic [3:0] exp_hold;

        // Vector table: each record's input is applied for one cycle and the
        // outputs are checked on the following falling edge.
        for (int j = 0; j < 16; j++) begin
            // ch0 clean rise
            tbl[j].in   = 4'b0101;
            tbl[j].out  = (j >= 9) ? 4'b0101 : 4'b0100;
            tbl[j].rise = (j == 9) ? 4'b0001 : 4'b0000;
            tbl[j].fall = 4'b0000;
            tbl[j].busy = (j >= 2 && j <= 8) ? 4'b0001 : 4'b0000;
            // ch2 falls and ch3 rises together
            tbl[16+j].in   = 4'b1001;
            tbl[16+j].out  = (j >= 9) ? 4'b1001 : 4'b0101;
            tbl[16+j].rise = (j == 9) ? 4'b1000 : 4'b0000;
            tbl[16+j].fall = (j == 9) ? 4'b0100 : 4'b0000;
            tbl[16+j].busy = (j >= 2 && j <= 8) ? 4'b1100 : 4'b0000;
            // back to the reset pattern: ch0/ch3 fall, ch2 rises
            tbl[32+j].in   = 4'b0100;
            tbl[32+j].out  = (j >= 9) ? 4'b0100 : 4'b1001;
            tbl[32+j].rise = (j == 9) ? 4'b0100 : 4'b0000;
            tbl[32+j].fall = (j == 9) ? 4'b1001 : 4'b0000;
            tbl[32+j].busy = (j >= 2 && j <= 8) ? 4'b1101 : 4'b0000;
        end

        // Reset with the inputs opposite to the reset level.
        rst  = 1'b1;
        i_in = 4'b1011;
        repeat (3) tick();
        chk("rst_out", 0, o_out, 4'b0100);
        chk("rst_rise", 0, o_rise, 4'b0000);
        chk("rst_fall", 0, o_fall, 4'b0000);
        chk("rst_busy", 0, o_busy, 4'b0000);
        chk("rst_hold", 0, o_hold, 4'b0000);
        rst  = 1'b0;
        i_in = 4'b0100;
        for (int c = 1; c <= 15; c++) begin
            tick();
            chk("rel_out", c, o_out, 4'b0100);
            chk("rel_rise", c, o_rise, 4'b0000);
            chk("rel_fall", c, o_fall, 4'b0000);
            chk("rel_busy", c, o_busy, 4'b0000);
        end

        // Table-driven clean and simultaneous edges.
        for (int j = 0; j < 48; j++) begin
            i_in = tbl[j].in;
            tick();
            chk("tbl_out", j, o_out, tbl[j].out);
            chk("tbl_rise", j, o_rise, tbl[j].rise);
            chk("tbl_fall", j, o_fall, tbl[j].fall);
            chk("tbl_busy", j, o_busy, tbl[j].busy);
        end

        // Bounce on ch1: high 5, low 2, high 7, then low -> no change.
        for (int cyc = 0; cyc < 25; cyc++) begin
            i_in = {2'b01, ((cyc < 5) || (cyc >= 7 && cyc < 14)), 1'b0};
            tick();
            chk("bnc_out", cyc + 1, o_out, 4'b0100);
            chk("bnc_strobe", cyc + 1, o_rise | o_fall, 4'b0000);
            if (cyc + 1 == 7)  chk("bnc_busy", 7,  {3'b000, o_busy[1]}, 4'b0001);
            if (cyc + 1 == 8)  chk("bnc_busy", 8,  {3'b000, o_busy[1]}, 4'b0000);
            if (cyc + 1 == 16) chk("bnc_busy", 16, {3'b000, o_busy[1]}, 4'b0001);
            if (cyc + 1 == 17) chk("bnc_busy", 17, {3'b000, o_busy[1]}, 4'b0000);
        end

        // Same bounce, then high 20 cycles from cycle 16, then low.
        for (int cyc = 0; cyc < 50; cyc++) begin
            i_in = {2'b01, ((cyc < 5) || (cyc >= 7 && cyc < 14) || (cyc >= 16 && cyc < 36)), 1'b0};
            tick();
            chk("bnc2_out", cyc + 1, o_out, (cyc + 1 >= 26 && cyc + 1 < 46) ? 4'b0110 : 4'b0100);
            chk("bnc2_rise", cyc + 1, o_rise, (cyc + 1 == 26) ? 4'b0010 : 4'b0000);
            chk("bnc2_fall", cyc + 1, o_fall, (cyc + 1 == 46) ? 4'b0010 : 4'b0000);
        end

        // Reset while ch0 is mid-qualification (counter at 5).
        for (int cyc = 0; cyc < 7; cyc++) begin
            i_in = 4'b0101;
            tick();
        end
        chk("mid_busy", 7, o_busy, 4'b0001);
        rst = 1'b1;
        #1;
        chk("mid_rst_out", 0, o_out, 4'b0100);
        chk("mid_rst_busy", 0, o_busy, 4'b0000);
        chk("mid_rst_strobe", 0, o_rise | o_fall, 4'b0000);
        tick();
        rst = 1'b0;

        // After release: full requalification of ch0, then long-press window.
        for (int r = 1; r <= 60; r++) begin
            tick();
            exp_hold = 4'b0000;
            if (HOLD_EN) begin
                if (r == 32) exp_hold[2] = 1'b1;
                if (r == 42) exp_hold[0] = 1'b1;
            end
            chk("post_out", r, o_out, (r >= 10) ? 4'b0101 : 4'b0100);
            chk("post_rise", r, o_rise, (r == 10) ? 4'b0001 : 4'b0000);
            chk("post_fall", r, o_fall, 4'b0000);
            chk("post_hold", r, o_hold, exp_hold);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
